// File: rtl/mul_seq.sv
// mul_seq: multi-cycle 32x32 -> 32 unsigned multiplier built on the shared
// execute-stage ALU. It computes the low word of a*b by shift-and-add,
// walking the 32 bits of the multiplier one per TEST step. For every set bit
// it spends one SHIFT cycle (ra << i) and one ADD cycle (acc + shifted ra).
// No local adder or shifter exists; all arithmetic goes through the ALU.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any run and clears result
//   start      request, accepted only while idle
//   a, b       multiplicand / multiplier, captured on an accepted start
//   busy       high from the cycle after an accepted start through DONE
//   done       one-cycle pulse marking completion
//   result     product mod 2^32, held until the next completion or reset
//   alu_en     sequencer owns the ALU this cycle
//   alu_op     ALU opcode (0111 bit-test, 0100 shift-left, 0010 add)
//   alu_left   ALU left operand
//   alu_right  ALU right operand
//   alu_out    ALU result, combinational from op/left/right
module mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_en,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_left,
    output logic [31:0] alu_right,
    input  logic [31:0] alu_out
);

    localparam logic [3:0] OP_BTST = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [4:0] I_LAST  = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TEST  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] ra_r;
    logic [31:0] rb_r;
    logic [31:0] acc_r;
    logic [31:0] tmp_r;
    logic [4:0]  i_r;
    logic        busy_r;
    logic        done_r;
    logic        alu_en_r;
    logic [31:0] result_r;
    logic [3:0]  alu_op_s;
    logic [31:0] alu_left_s;
    logic [31:0] alu_right_s;

    // Next-state decode and ALU operand drive. Operands depend only on state
    // and local registers, never on alu_out, so there is no loop through the ALU.
    always_comb begin
        state_nxt_s = state_r;
        alu_op_s    = 4'd0;
        alu_left_s  = 32'd0;
        alu_right_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_TEST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TEST: begin
                alu_op_s    = OP_BTST;
                alu_left_s  = rb_r;
                alu_right_s = {27'd0, i_r};
                if (alu_out[0]) begin
                    state_nxt_s = ST_SHIFT;
                end else if (i_r == I_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_TEST;
                end
            end
            ST_SHIFT: begin
                alu_op_s    = OP_SHL;
                alu_left_s  = ra_r;
                alu_right_s = {27'd0, i_r};
                state_nxt_s = ST_ADD;
            end
            ST_ADD: begin
                alu_op_s    = OP_ADD;
                alu_left_s  = acc_r;
                alu_right_s = tmp_r;
                if (i_r == I_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_TEST;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status outputs decoded from the next state,
    // so busy/done/alu_en line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            alu_en_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            done_r   <= (state_nxt_s == ST_DONE);
            alu_en_r <= (state_nxt_s == ST_TEST) || (state_nxt_s == ST_SHIFT) ||
                        (state_nxt_s == ST_ADD);
        end
    end

    // Datapath registers: operand capture, bit index, partial product, result.
    // The index never wraps; bit 31 always leads to DONE instead of increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            ra_r     <= 32'd0;
            rb_r     <= 32'd0;
            acc_r    <= 32'd0;
            tmp_r    <= 32'd0;
            i_r      <= 5'd0;
            result_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ra_r  <= a;
                        rb_r  <= b;
                        acc_r <= 32'd0;
                        i_r   <= 5'd0;
                    end
                end
                ST_TEST: begin
                    if (!alu_out[0] && (i_r != I_LAST)) begin
                        i_r <= i_r + 5'd1;
                    end
                end
                ST_SHIFT: begin
                    tmp_r <= alu_out;
                end
                ST_ADD: begin
                    acc_r <= alu_out;
                    if (i_r != I_LAST) begin
                        i_r <= i_r + 5'd1;
                    end
                end
                ST_DONE: begin
                    result_r <= acc_r;
                end
                default: begin
                    i_r <= 5'd0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign alu_en    = alu_en_r;
    assign alu_op    = alu_op_s;
    assign alu_left  = alu_left_s;
    assign alu_right = alu_right_s;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: provides the shared ALU, drives directed and random
// multiplies, and compares against the arithmetic product a*b and the cycle
// count 33 + 2*popcount(b).
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [31:0] alu_left;
    logic [31:0] alu_right;
    logic [31:0] alu_out;

    int checks = 0;
    int errors = 0;

    mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_left  (alu_left),
        .alu_right (alu_right),
        .alu_out   (alu_out)
    );

    always #5 clk = ~clk;

    // Shared execute-stage ALU as seen by the sequencer.
    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            4'b0111: alu_out = {31'd0, alu_left[alu_right[4:0]]};
            4'b0100: alu_out = alu_left << alu_right[4:0];
            4'b0010: alu_out = alu_left + alu_right;
            default: alu_out = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle N+1
    // with the DUT idle again, so a following call is a back-to-back start.
    task automatic run_mul(input logic [31:0] av, input logic [31:0] bv, input bit poke);
        logic [31:0] exp_prod;
        int          n;
        int          pc;
        int          shifts;
        int          adds;
        exp_prod = av * bv;
        pc       = $countones(bv);
        n        = 33 + 2 * pc;
        shifts   = 0;
        adds     = 0;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (alu_op == 4'b0100) shifts++;
            if (alu_op == 4'b0010) adds++;
            check("busy", {31'd0, busy}, {31'd0, k <= n});
            check("done", {31'd0, done}, {31'd0, k == n});
            check("alu_en", {31'd0, alu_en}, {31'd0, k < n});
            if (k == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            if (poke && k == 5) begin
                start = 1'b1;
                a     = 32'd1;
                b     = 32'd1;
            end
            if (poke && k == 6) start = 1'b0;
            // start during the DONE cycle must be ignored
            if (poke && k == n) start = 1'b1;
            if (k == n + 1) start = 1'b0;
        end
        check("result", result, exp_prod);
        check("shift_ops", 32'(shifts), 32'(pc));
        check("add_ops", 32'(adds), 32'(pc));
        check("idle_alu", alu_left | alu_right | {28'd0, alu_op}, 32'd0);
    endtask

    // Start a run and assert reset during cycle 'cyc'; the run must vanish.
    task automatic run_abort(input logic [31:0] av, input logic [31:0] bv, input int cyc);
        int dones;
        dones = 0;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        for (int k = 1; k <= cyc; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dones++;
            if (k == cyc) reset = 1'b1;
        end
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_alu_en", {31'd0, alu_en}, 32'd0);
        check("abort_result", result, 32'd0);
        for (int k = 0; k < 100; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dones), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_alu_en", {31'd0, alu_en}, 32'd0);
        check("rst_alu", alu_left | alu_right | {28'd0, alu_op}, 32'd0);
        reset = 1'b0;

        run_mul(32'd3, 32'd5, 1'b1);
        repeat (2) @(negedge clk);
        run_mul(32'h12345678, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        repeat (2) @(negedge clk);
        run_mul(32'h00010000, 32'h00010000, 1'b0);
        run_mul(32'd7, 32'd6, 1'b0);
        repeat (2) @(negedge clk);
        run_abort(32'd3, 32'd5, 10);
        run_mul(32'd2, 32'd2, 1'b0);

        for (int r = 0; r < 14; r++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (r % 3 == 0) rb = rb & $urandom & $urandom;
            run_mul(ra, rb, r[0]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
